huffman_decoder: RTL and testbench
==================================

Name: huffman_decoder

Overview:
Bit-serial JPEG Huffman decoder that inverts the encoder's (run,size) code lookup. It accepts a compressed bitstream one bit per cycle (stuffed 0x00 bytes after 0xFF already removed upstream). It decodes canonical codes of the ITU-T T.81 Annex K.5 luminance AC table, then reads the appended amplitude bits and sign-extends them with EXTEND. It emits one (run, size, amplitude) symbol per handshake to the run-length/dequant stage.

Parameters:
AMP_W, 12, width of signed amplitude output; must be >= 11 (>= 12 when HUFF_DC_EN)
ERR_STICKY, 1, 1: error state held until flush_in/rst_in; 0: auto-return to S_CODE one cycle after err_out pulse

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
flush_in  input  1  discard partial code/amplitude, clear error, return to S_CODE
bit_in  input  1  next stream bit, MSB-first
bit_valid_in  input  1  bit_in valid
bit_ready_out  output  1  decoder can accept a bit this cycle
dc_mode_in  input  1  select DC table (HUFF_DC_EN only; ignored otherwise)
run_out  output  4  zero run of decoded symbol
size_out  output  4  amplitude category (0..11)
amp_out  output  AMP_W  signed amplitude after EXTEND; 0 when size_out=0
eob_out  output  1  symbol is EOB (0x00)
zrl_out  output  1  symbol is ZRL (0xF0)
sym_valid_out  output  1  symbol outputs valid
sym_ready_in  input  1  consumer accepts symbol
err_out  output  1  no code matched within 16 bits

Behaviour:
- Reset: state S_CODE; all outputs 0 except bit_ready_out=1 in the cycle after reset; code accumulator, length counter, amplitude register all 0.
- Bit accepted iff bit_valid_in && bit_ready_out. bit_ready_out=1 only in S_CODE and S_AMP.
- Table: BITS[1..16]={0,2,1,3,3,2,4,3,5,5,4,4,0,0,1,125}; 162-entry HUFFVAL ROM in Annex K.5 order; MINCODE/MAXCODE/VALPTR per length derived per T.81 F.2.2.3 and held as constants.
- S_CODE: code<=(code<<1)|bit, len++. If BITS[len]!=0 && code<=MAXCODE[len], then sym=HUFFVAL[VALPTR[len]+code-MINCODE[len]], run=sym[7:4], size=sym[3:0]. If size=0, go S_OUT; else set amp counter=size and go S_AMP. If len reaches 16 without a match, go S_ERR.
- S_AMP: shift bits into raw, MSB-first. On the last bit: if raw[size-1]=0, amp=raw-(2^size-1), else amp=raw, sign-extended to AMP_W. Then go S_OUT.
- S_OUT: sym_valid_out=1. Outputs are registered and stable until sym_valid_out && sym_ready_in, then go S_CODE. No bits are consumed in S_OUT.
- Latency: sym_valid_out rises on the cycle after the final code/amplitude bit is accepted.
- eob_out = (run=0 && size=0); zrl_out = (run=15 && size=0). Both are qualified by sym_valid_out.
- S_ERR: err_out=1, bit_ready_out=0, sym_valid_out=0. ERR_STICKY=0: err_out is a one-cycle pulse, then S_CODE with the accumulator cleared.
- flush_in has priority over every state and over a simultaneous bit; the bit offered that cycle is not consumed. It clears the accumulator, length, amplitude and err_out, and drops any pending symbol. Flush is used at restart markers and end of scan.
- rst_in mid-code or mid-symbol: the partial code is discarded, with the same outputs as at reset.
- Code length 16 match with BITS[16]: VALPTR+offset must stay within 0..161. This holds by construction and is asserted in simulation.

Optional Feature:
HUFF_DC_EN:
- Defined: dc_mode_in=1 selects the K.3 luminance DC table, BITS={0,1,5,1,1,1,1,1,1,0,0,0,0,0,0,0}, HUFFVAL=0..11. The symbol is the size only; run_out=0, eob_out=zrl_out=0, size up to 11. dc_mode_in is sampled only while S_CODE has len=0.
- Undefined: dc_mode_in is ignored, only the AC table exists, and there is no DC ROM.

Test Plan:
- Bits 1,0,1,0 -> one cycle after 4th bit: sym_valid_out=1, run=0, size=0, amp=0, eob_out=1.
- Bits 0,0 then 1 -> run=0, size=1, amp=+1. Bits 0,0 then 0 -> amp=-1. Bits 0,1 then 0,1 -> size=2, amp=-2.
- Bits 1,1,1,1,1,1,1,1,0,0,1 -> run=15, size=0, zrl_out=1. Bits 1,1,0,0 then 1 -> run=1, size=1, amp=+1.
- sym_ready_in low 3 cycles during S_OUT -> outputs unchanged, bit_ready_out=0, no bits lost; symbol taken on 4th cycle.
- Sixteen 1-bits -> err_out=1, bit_ready_out=0 held (ERR_STICKY=1). Then flush_in with bit_valid_in=1 -> S_CODE, err_out=0, bit not consumed; next 1,0,1,0 decodes EOB.
- HUFF_DC_EN, dc_mode_in=1: bits 0,0 -> size=0, amp=0. Bits 1,0,0 then 1,0,1 -> size=3, amp=+5. Bits 0,1,0 then 0 -> size=1, amp=-1.

Source files
------------

// File: rtl/huffman_decoder_if.sv
// Bitstream-in / symbol-out handshake bundle for huffman_decoder.
// slave  = decoder side, master = producer/consumer side.
interface huffman_decoder_if #(
  parameter int AMP_W = 12
);
  logic             flush_in;
  logic             bit_in;
  logic             bit_valid_in;
  logic             bit_ready_out;
  logic             dc_mode_in;
  logic [3:0]       run_out;
  logic [3:0]       size_out;
  logic [AMP_W-1:0] amp_out;
  logic             eob_out;
  logic             zrl_out;
  logic             sym_valid_out;
  logic             sym_ready_in;
  logic             err_out;

  modport slave (
    input  flush_in, bit_in, bit_valid_in, dc_mode_in, sym_ready_in,
    output bit_ready_out, run_out, size_out, amp_out, eob_out, zrl_out,
           sym_valid_out, err_out
  );

  modport master (
    output flush_in, bit_in, bit_valid_in, dc_mode_in, sym_ready_in,
    input  bit_ready_out, run_out, size_out, amp_out, eob_out, zrl_out,
           sym_valid_out, err_out
  );
endinterface

// File: rtl/huffman_decoder.sv
// Bit-serial JPEG Huffman decoder: canonical luminance AC table (T.81 K.5),
// followed by amplitude bits and EXTEND.  Define HUFF_DC_EN to add the K.3
// luminance DC table, selected by dc_mode_in at the start of each code.
// AMP_W must be >= 11 (>= 12 with HUFF_DC_EN).
module huffman_decoder #(
  parameter int AMP_W      = 12,
  parameter bit ERR_STICKY = 1'b1
) (
  input logic              clk_in,
  input logic              rst_in,
  huffman_decoder_if.slave dec
);
  typedef enum logic [1:0] {S_CODE = 2'd0, S_AMP = 2'd1, S_OUT = 2'd2, S_ERR = 2'd3} state_t;

  // Per-length tables indexed by (code length - 1).
  localparam logic        AC_HAS [0:15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                            1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [15:0] AC_MAX [0:15] = '{16'd0, 16'd1, 16'd4, 16'd12, 16'd28, 16'd59, 16'd123, 16'd250,
                                            16'd506, 16'd1018, 16'd2041, 16'd4087, 16'd0, 16'd0, 16'd32704, 16'd65534};
  localparam logic [15:0] AC_MIN [0:15] = '{16'd0, 16'd0, 16'd4, 16'd10, 16'd26, 16'd58, 16'd120, 16'd248,
                                            16'd502, 16'd1014, 16'd2038, 16'd4084, 16'd0, 16'd0, 16'd32704, 16'd65410};
  localparam logic [7:0]  AC_VP  [0:15] = '{8'd0, 8'd0, 8'd2, 8'd3, 8'd6, 8'd9, 8'd11, 8'd15,
                                            8'd18, 8'd23, 8'd28, 8'd32, 8'd0, 8'd0, 8'd36, 8'd37};
  localparam logic [7:0] AC_VAL [0:161] = '{
    8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'h11, 8'h05, 8'h12, 8'h21, 8'h31, 8'h41, 8'h06, 8'h13, 8'h51, 8'h61, 8'h07,
    8'h22, 8'h71, 8'h14, 8'h32, 8'h81, 8'h91, 8'ha1, 8'h08, 8'h23, 8'h42, 8'hb1, 8'hc1, 8'h15, 8'h52, 8'hd1, 8'hf0,
    8'h24, 8'h33, 8'h62, 8'h72, 8'h82, 8'h09, 8'h0a, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1a, 8'h25, 8'h26, 8'h27, 8'h28,
    8'h29, 8'h2a, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h3a, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49,
    8'h4a, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59, 8'h5a, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69,
    8'h6a, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h78, 8'h79, 8'h7a, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89,
    8'h8a, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97, 8'h98, 8'h99, 8'h9a, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6, 8'ha7,
    8'ha8, 8'ha9, 8'haa, 8'hb2, 8'hb3, 8'hb4, 8'hb5, 8'hb6, 8'hb7, 8'hb8, 8'hb9, 8'hba, 8'hc2, 8'hc3, 8'hc4, 8'hc5,
    8'hc6, 8'hc7, 8'hc8, 8'hc9, 8'hca, 8'hd2, 8'hd3, 8'hd4, 8'hd5, 8'hd6, 8'hd7, 8'hd8, 8'hd9, 8'hda, 8'he1, 8'he2,
    8'he3, 8'he4, 8'he5, 8'he6, 8'he7, 8'he8, 8'he9, 8'hea, 8'hf1, 8'hf2, 8'hf3, 8'hf4, 8'hf5, 8'hf6, 8'hf7, 8'hf8,
    8'hf9, 8'hfa};
`ifdef HUFF_DC_EN
  localparam logic        DC_HAS [0:15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                            1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [15:0] DC_MAX [0:15] = '{16'd0, 16'd0, 16'd6, 16'd14, 16'd30, 16'd62, 16'd126, 16'd254,
                                            16'd510, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
  localparam logic [15:0] DC_MIN [0:15] = '{16'd0, 16'd0, 16'd2, 16'd14, 16'd30, 16'd62, 16'd126, 16'd254,
                                            16'd510, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
  localparam logic [7:0]  DC_VP  [0:15] = '{8'd0, 8'd0, 8'd1, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10,
                                            8'd11, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
`endif

  // EXTEND: a leading 0 amplitude bit marks a negative value raw-(2^size-1).
  function automatic logic [AMP_W-1:0] extend_amp(input logic [10:0] raw, input logic [3:0] size);
    logic [AMP_W-1:0] raw_w;
    logic [AMP_W-1:0] mask_w;
    raw_w  = AMP_W'(raw);
    mask_w = (AMP_W'(1'b1) << size) - AMP_W'(1'b1);
    if (raw[size - 4'd1] == 1'b0) begin
      return raw_w - mask_w;
    end else begin
      return raw_w;
    end
  endfunction

  state_t           state_q, state_d;
  logic [14:0]      code_q, code_d;
  logic [3:0]       len_q, len_d;
  logic [9:0]       raw_q, raw_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       sym_q, sym_d;
  logic [AMP_W-1:0] amp_q, amp_d;
  logic             dc_sel_q, dc_sel_d;
  logic             bit_ready_q, bit_ready_d, sym_valid_q, sym_valid_d, err_q, err_d;
  logic             eob_q, eob_d, zrl_q, zrl_d;
  logic [3:0]       run_out_q, run_out_d, size_out_q, size_out_d;
  logic [AMP_W-1:0] amp_out_q, amp_out_d;

  logic             take_s, dc_s, hit_s;
  logic [15:0]      code_shift_s;
  logic [10:0]      raw_shift_s;
  logic [7:0]       idx_s, val_s;

  assign take_s       = dec.bit_valid_in && bit_ready_q;
  assign code_shift_s = {code_q, dec.bit_in};
  assign raw_shift_s  = {raw_q, dec.bit_in};
`ifdef HUFF_DC_EN
  assign dc_s = (len_q == 4'd0) ? dec.dc_mode_in : dc_sel_q;
`else
  assign dc_s = 1'b0;
`endif

  // Canonical-code match of the shifted code against the active table.
  always_comb begin
    hit_s = 1'b0;
    idx_s = 8'd0;
    val_s = 8'd0;
`ifdef HUFF_DC_EN
    if (dc_s) begin
      hit_s = DC_HAS[len_q] && (code_shift_s <= DC_MAX[len_q]);
      idx_s = DC_VP[len_q] + 8'(code_shift_s - DC_MIN[len_q]);
      val_s = {4'd0, idx_s[3:0]};
    end else begin
`endif
      hit_s = AC_HAS[len_q] && (code_shift_s <= AC_MAX[len_q]);
      idx_s = AC_VP[len_q] + 8'(code_shift_s - AC_MIN[len_q]);
      if (hit_s) begin
        val_s = AC_VAL[idx_s];
      end else begin
        val_s = 8'd0;
      end
`ifdef HUFF_DC_EN
    end
`endif
  end

  // Next-state and datapath update; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    len_d    = len_q;
    raw_d    = raw_q;
    cnt_d    = cnt_q;
    sym_d    = sym_q;
    amp_d    = amp_q;
    dc_sel_d = dc_sel_q;
    if (dec.flush_in) begin
      state_d  = S_CODE;
      code_d   = 15'd0;
      len_d    = 4'd0;
      raw_d    = 10'd0;
      cnt_d    = 4'd0;
      sym_d    = 8'd0;
      amp_d    = '0;
      dc_sel_d = 1'b0;
    end else begin
      case (state_q)
        S_CODE: begin
          if (take_s) begin
            dc_sel_d = dc_s;
            code_d   = 15'd0;
            len_d    = 4'd0;
            if (hit_s) begin
              sym_d = val_s;
              raw_d = 10'd0;
              amp_d = '0;
              cnt_d = val_s[3:0];
              if (val_s[3:0] == 4'd0) begin
                state_d = S_OUT;
              end else begin
                state_d = S_AMP;
              end
            end else if (len_q == 4'd15) begin
              state_d = S_ERR;
            end else begin
              code_d = code_shift_s[14:0];
              len_d  = len_q + 4'd1;
            end
          end else begin
            state_d = S_CODE;
          end
        end
        S_AMP: begin
          if (take_s) begin
            raw_d = raw_shift_s[9:0];
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              amp_d   = extend_amp(raw_shift_s, sym_q[3:0]);
              state_d = S_OUT;
            end else begin
              state_d = S_AMP;
            end
          end else begin
            state_d = S_AMP;
          end
        end
        S_OUT: begin
          if (dec.sym_ready_in) begin
            state_d = S_CODE;
          end else begin
            state_d = S_OUT;
          end
        end
        S_ERR: begin
          if (ERR_STICKY) begin
            state_d = S_ERR;
          end else begin
            state_d = S_CODE;
          end
        end
        default: state_d = S_CODE;
      endcase
    end
  end

  // Registered outputs derived from the next state and next symbol.
  always_comb begin
    bit_ready_d = (state_d == S_CODE) || (state_d == S_AMP);
    sym_valid_d = (state_d == S_OUT);
    err_d       = (state_d == S_ERR);
    if (state_d == S_OUT) begin
      run_out_d  = sym_d[7:4];
      size_out_d = sym_d[3:0];
      amp_out_d  = amp_d;
      eob_d      = (sym_d == 8'h00) && !dc_sel_d;
      zrl_d      = (sym_d == 8'hF0) && !dc_sel_d;
    end else begin
      run_out_d  = 4'd0;
      size_out_d = 4'd0;
      amp_out_d  = '0;
      eob_d      = 1'b0;
      zrl_d      = 1'b0;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_CODE;
      code_q      <= 15'd0;
      len_q       <= 4'd0;
      raw_q       <= 10'd0;
      cnt_q       <= 4'd0;
      sym_q       <= 8'd0;
      amp_q       <= '0;
      dc_sel_q    <= 1'b0;
      bit_ready_q <= 1'b1;
      sym_valid_q <= 1'b0;
      err_q       <= 1'b0;
      eob_q       <= 1'b0;
      zrl_q       <= 1'b0;
      run_out_q   <= 4'd0;
      size_out_q  <= 4'd0;
      amp_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      len_q       <= len_d;
      raw_q       <= raw_d;
      cnt_q       <= cnt_d;
      sym_q       <= sym_d;
      amp_q       <= amp_d;
      dc_sel_q    <= dc_sel_d;
      bit_ready_q <= bit_ready_d;
      sym_valid_q <= sym_valid_d;
      err_q       <= err_d;
      eob_q       <= eob_d;
      zrl_q       <= zrl_d;
      run_out_q   <= run_out_d;
      size_out_q  <= size_out_d;
      amp_out_q   <= amp_out_d;
    end
  end

  assign dec.bit_ready_out = bit_ready_q;
  assign dec.sym_valid_out = sym_valid_q;
  assign dec.err_out       = err_q;
  assign dec.eob_out       = eob_q;
  assign dec.zrl_out       = zrl_q;
  assign dec.run_out       = run_out_q;
  assign dec.size_out      = size_out_q;
  assign dec.amp_out       = amp_out_q;

  huffman_decoder_chk u_chk (
    .clk_in (clk_in),
    .hit_i  (take_s && hit_s && (state_q == S_CODE)),
    .idx_i  (idx_s)
  );
endmodule

// Simulation checker: a matched code must always index inside the value ROM.
module huffman_decoder_chk (
  input logic       clk_in,
  input logic       hit_i,
  input logic [7:0] idx_i
);
  // Bound check of the ROM index on every matched code.
  always @(posedge clk_in) begin
    if (hit_i) begin
      assert (idx_i <= 8'd161);
    end
  end
endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder: expected symbols are queued when their
// bits are driven and compared when the decoder presents them.
module tb_huffman_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct packed {
    logic [3:0]  run;
    logic [3:0]  size;
    logic [11:0] amp;
    logic        eob;
    logic        zrl;
  } exp_t;
  exp_t sb_q[$];

  huffman_decoder_if #(.AMP_W(12)) dif ();

  huffman_decoder #(.AMP_W(12), .ERR_STICKY(1'b1)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .dec    (dif)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    int w;
    w = 0;
    dif.bit_in       = b;
    dif.bit_valid_in = 1'b1;
    while (dif.bit_ready_out !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) chk("bit_ready_timeout", 32'd0, 32'd1);
    tick();
    dif.bit_valid_in = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic push(input logic [3:0] r, input logic [3:0] s, input logic [11:0] a,
                      input logic e, input logic z);
    exp_t x;
    x.run = r; x.size = s; x.amp = a; x.eob = e; x.zrl = z;
    sb_q.push_back(x);
  endtask

  task automatic compare_front(input string tag);
    exp_t x;
    if (sb_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      x = sb_q.pop_front();
      chk({tag, "_run"},  32'(dif.run_out),  32'(x.run));
      chk({tag, "_size"}, 32'(dif.size_out), 32'(x.size));
      chk({tag, "_amp"},  32'(dif.amp_out),  32'(x.amp));
      chk({tag, "_eob"},  32'(dif.eob_out),  32'(x.eob));
      chk({tag, "_zrl"},  32'(dif.zrl_out),  32'(x.zrl));
    end
  endtask

  // Symbol must be valid right after the last bit; then handshake it.
  task automatic collect(input string tag);
    int w;
    chk({tag, "_latency_valid"}, 32'(dif.sym_valid_out), 32'd1);
    w = 0;
    while (dif.sym_valid_out !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    compare_front(tag);
    dif.sym_ready_in = 1'b1;
    tick();
    dif.sym_ready_in = 1'b0;
    chk({tag, "_valid_drop"}, 32'(dif.sym_valid_out), 32'd0);
    chk({tag, "_ready_back"}, 32'(dif.bit_ready_out), 32'd1);
  endtask

  task automatic decode(input string tag, input logic [31:0] code, input int clen,
                        input logic [31:0] ampb, input int alen);
    send_bits(code, clen);
    if (alen > 0) send_bits(ampb, alen);
    collect(tag);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"},     32'(dif.sym_valid_out), 32'd0);
    chk({tag, "_err"},       32'(dif.err_out),       32'd0);
    chk({tag, "_bit_ready"}, 32'(dif.bit_ready_out), 32'd1);
    chk({tag, "_size"},      32'(dif.size_out),      32'd0);
    chk({tag, "_amp"},       32'(dif.amp_out),       32'd0);
    chk({tag, "_eob"},       32'(dif.eob_out),       32'd0);
  endtask

  initial begin
    exp_t hold;
    dif.flush_in     = 1'b0;
    dif.bit_in       = 1'b0;
    dif.bit_valid_in = 1'b0;
    dif.dc_mode_in   = 1'b0;
    dif.sym_ready_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");

    // Basic AC symbols.
    push(4'd0, 4'd0, 12'h000, 1'b1, 1'b0);
    decode("eob", 32'b1010, 4, 32'd0, 0);
    push(4'd0, 4'd1, 12'h001, 1'b0, 1'b0);
    decode("s1_pos", 32'b00, 2, 32'b1, 1);
    push(4'd0, 4'd1, 12'hFFF, 1'b0, 1'b0);
    decode("s1_neg", 32'b00, 2, 32'b0, 1);
    push(4'd0, 4'd2, 12'hFFE, 1'b0, 1'b0);
    decode("s2_neg", 32'b01, 2, 32'b01, 2);
    push(4'd15, 4'd0, 12'h000, 1'b0, 1'b1);
    decode("zrl", 32'b11111111001, 11, 32'd0, 0);
    push(4'd1, 4'd1, 12'h001, 1'b0, 1'b0);
    decode("r1s1", 32'b1100, 4, 32'b1, 1);
    push(4'd0, 4'd7, 12'hF82, 1'b0, 1'b0);
    decode("len8", 32'b11111000, 8, 32'b0000001, 7);
    push(4'd8, 4'd2, 12'h003, 1'b0, 1'b0);
    decode("len15", 32'b111111111000000, 15, 32'b11, 2);
    push(4'd0, 4'd9, 12'h100, 1'b0, 1'b0);
    decode("len16_first", 32'hFF82, 16, 32'b100000000, 9);
    push(4'd15, 4'd10, 12'hC01, 1'b0, 1'b0);
    decode("len16_last", 32'hFFFE, 16, 32'd0, 10);

    // Consumer stall: symbol held, no bit consumed while stalled.
    push(4'd0, 4'd1, 12'h001, 1'b0, 1'b0);
    send_bits(32'b001, 3);
    chk("stall_latency_valid", 32'(dif.sym_valid_out), 32'd1);
    hold = sb_q[0];
    dif.bit_in       = 1'b1;
    dif.bit_valid_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall_valid", 32'(dif.sym_valid_out), 32'd1);
      chk("stall_bit_ready", 32'(dif.bit_ready_out), 32'd0);
      chk("stall_amp", 32'(dif.amp_out), 32'(hold.amp));
    end
    compare_front("stall");
    dif.sym_ready_in = 1'b1;
    tick();
    dif.sym_ready_in = 1'b0;
    chk("stall_taken", 32'(dif.sym_valid_out), 32'd0);
    push(4'd0, 4'd0, 12'h000, 1'b1, 1'b0);
    send_bit(1'b1);
    decode("post_stall_eob", 32'b010, 3, 32'd0, 0);

    // Sixteen ones: sticky error, then flush with a bit offered.
    send_bits(32'hFFFF, 16);
    chk("err_set", 32'(dif.err_out), 32'd1);
    chk("err_bit_ready", 32'(dif.bit_ready_out), 32'd0);
    chk("err_no_valid", 32'(dif.sym_valid_out), 32'd0);
    dif.bit_in       = 1'b1;
    dif.bit_valid_in = 1'b1;
    tick();
    tick();
    chk("err_sticky", 32'(dif.err_out), 32'd1);
    dif.flush_in = 1'b1;
    tick();
    dif.flush_in     = 1'b0;
    dif.bit_valid_in = 1'b0;
    check_idle("flush");
    push(4'd0, 4'd0, 12'h000, 1'b1, 1'b0);
    decode("post_flush_eob", 32'b1010, 4, 32'd0, 0);

    // Reset in the middle of a code.
    send_bits(32'b11, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mid_reset");
    push(4'd0, 4'd0, 12'h000, 1'b1, 1'b0);
    decode("post_reset_eob", 32'b1010, 4, 32'd0, 0);

`ifdef HUFF_DC_EN
    dif.dc_mode_in = 1'b1;
    push(4'd0, 4'd0, 12'h000, 1'b0, 1'b0);
    decode("dc_s0", 32'b00, 2, 32'd0, 0);
    push(4'd0, 4'd3, 12'h005, 1'b0, 1'b0);
    decode("dc_s3", 32'b100, 3, 32'b101, 3);
    push(4'd0, 4'd1, 12'hFFF, 1'b0, 1'b0);
    decode("dc_s1", 32'b010, 3, 32'b0, 1);
    dif.dc_mode_in = 1'b0;
`endif

    chk("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
